y86_fetch_unit: RTL and testbench

- Y86-64 pipeline fetch stage. Sits between the fetch PC register (source of the predicted PC) and the decode pipeline register.
- Selects the fetch PC, including branch-mispredict and ret correction.
- Reads the instruction byte-by-byte over a handshaked instruction-memory port, splits it into fields, and computes valP and the next predicted PC.
- Presents the result to decode with a valid/ready handshake.

---
 rtl/y86_pkg.sv | 37 +++
 rtl/y86_insn_align.sv | 37 +++
 rtl/y86_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_y86_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode/status constants, fetch states and length decode
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_INS = 2'd0;
  localparam logic [1:0] STAT_AOK = 2'd1;
  localparam logic [1:0] STAT_HLT = 2'd2;
  localparam logic [1:0] STAT_ADR = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {S_SEL, S_REQ, S_OUT, S_HALT} fetch_state_e;

  // Instruction length in bytes; 0 marks an invalid icode.
  function automatic logic [3:0] insn_len(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:             insn_len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: insn_len = 4'd2;
      I_JXX, I_CALL:                    insn_len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     insn_len = 4'd10;
      default:                          insn_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_insn_align.sv
// rtl/y86_insn_align.sv - splits fetched bytes 1..9 into rA/rB/valC, computes valP and predicted PC
module y86_insn_align
  import y86_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int MAX_LEN = 10
) (
  input  logic [(MAX_LEN-1)*8-1:0] insn_tail,
  input  logic [3:0]               icode,
  input  logic [3:0]               nbytes,
  input  logic [ADDR_W-1:0]        pc,
  output logic [3:0]               ra,
  output logic [3:0]               rb,
  output logic [63:0]              valc,
  output logic [ADDR_W-1:0]        valp,
  output logic [ADDR_W-1:0]        pc_predict
);

  logic [3:0] len;

  // Fields only appear once every byte that carries them has arrived.
  always_comb begin
    len  = insn_len(icode);
    ra   = RNONE;
    rb   = RNONE;
    valc = '0;
    if ((len == 4'd2 || len == 4'd10) && nbytes >= 4'd2) begin
      ra = insn_tail[7:4];
      rb = insn_tail[3:0];
    end
    if (nbytes == len && len == 4'd9)       valc = insn_tail[63:0];
    else if (nbytes == len && len == 4'd10) valc = insn_tail[71:8];
    valp       = pc + ADDR_W'(len);
    pc_predict = (icode == I_JXX || icode == I_CALL) ? valc[ADDR_W-1:0] : valp;
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// rtl/y86_fetch_unit.sv - Y86-64 fetch stage: PC select, byte-serial imem read, decode handoff
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int MAX_LEN = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] F_predPC,
  input  logic [3:0]        M_icode,
  input  logic              M_Cnd,
  input  logic [ADDR_W-1:0] M_valA,
  input  logic [3:0]        W_icode,
  input  logic [ADDR_W-1:0] W_valM,
  input  logic              ret_pending,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        f_icode,
  output logic [3:0]        f_ifun,
  output logic [3:0]        f_rA,
  output logic [3:0]        f_rB,
  output logic [63:0]       f_valC,
  output logic [ADDR_W-1:0] f_valP,
  output logic [ADDR_W-1:0] f_PC_PREDICT,
  output logic [1:0]        f_stat,
  output logic              f_busy
);

  fetch_state_e              state_q, state_d;
  logic [ADDR_W-1:0]         pc_q, pc_d;
  logic [3:0]                k_q, k_d;
  logic [(MAX_LEN-1)*8-1:0]  tail_q, tail_d;
  logic [3:0]                icode_q, icode_d, ifun_q, ifun_d;
  logic [3:0]                ra_q, ra_d, rb_q, rb_d;
  logic [63:0]               valc_q, valc_d;
  logic [ADDR_W-1:0]         valp_q, valp_d, pred_q, pred_d;
  logic [1:0]                stat_q, stat_d;
  logic [3:0]                cur_icode, cur_len;
  logic                      done;
  logic [3:0]                al_ra, al_rb;
  logic [63:0]               al_valc;
  logic [ADDR_W-1:0]         al_valp, al_pred;

  // Aligner sees the buffer including the byte landing this cycle.
  y86_insn_align #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) u_align (
    .insn_tail  (tail_d),
    .icode      (icode_d),
    .nbytes     (k_d),
    .pc         (pc_q),
    .ra         (al_ra),
    .rb         (al_rb),
    .valc       (al_valc),
    .valp       (al_valp),
    .pc_predict (al_pred)
  );

  always_comb begin
    pc_d    = pc_q;
    k_d     = k_q;
    tail_d  = tail_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    if (state_q == S_SEL && !ret_pending) begin
      if (M_icode == I_JXX && !M_Cnd) pc_d = M_valA;
      else if (W_icode == I_RET)      pc_d = W_valM;
      else                            pc_d = F_predPC;
      k_d     = '0;
      tail_d  = '0;
      icode_d = I_HALT;
      ifun_d  = '0;
    end else if (state_q == S_REQ && imem_ack && !imem_err) begin
      k_d = k_q + 4'd1;
      if (k_q == 4'd0) begin
        icode_d = imem_rdata[7:4];
        ifun_d  = imem_rdata[3:0];
      end else begin
        tail_d[8*(int'(k_q)-1) +: 8] = imem_rdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    valc_d    = valc_q;
    valp_d    = valp_q;
    pred_d    = pred_q;
    done      = 1'b0;
    cur_icode = (k_q == 4'd0) ? imem_rdata[7:4] : icode_q;
    cur_len   = insn_len(cur_icode);
    case (state_q)
      S_SEL: if (!ret_pending) state_d = S_REQ;
      S_REQ: if (imem_ack) begin
        done = 1'b1;
        if (imem_err)                stat_d = STAT_ADR;
        else if (cur_len == 4'd0)    stat_d = STAT_INS;
        else if (k_d == cur_len)     stat_d = (cur_icode == I_HALT) ? STAT_HLT : STAT_AOK;
        else                         done   = 1'b0;
      end
      S_OUT: if (out_ready) state_d = (stat_q == STAT_AOK) ? S_SEL : S_HALT;
      default: ;
    endcase
    if (done) begin
      state_d = S_OUT;
      ra_d    = al_ra;
      rb_d    = al_rb;
      valc_d  = al_valc;
      valp_d  = al_valp;
      pred_d  = al_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SEL;
      pc_q    <= '0;
      k_q     <= '0;
      tail_q  <= '0;
      icode_q <= '0;
      ifun_q  <= '0;
      ra_q    <= RNONE;
      rb_q    <= RNONE;
      valc_q  <= '0;
      valp_q  <= '0;
      pred_q  <= '0;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      k_q     <= k_d;
      tail_q  <= tail_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      pred_q  <= pred_d;
      stat_q  <= stat_d;
    end
  end

  assign imem_req     = (state_q == S_REQ);
  assign imem_addr    = pc_q + ADDR_W'(k_q);
  assign out_valid    = (state_q == S_OUT);
  assign f_busy       = (state_q != S_OUT);
  assign f_icode      = icode_q;
  assign f_ifun       = ifun_q;
  assign f_rA         = ra_q;
  assign f_rB         = rb_q;
  assign f_valC       = valc_q;
  assign f_valP       = valp_q;
  assign f_PC_PREDICT = pred_q;
  assign f_stat       = stat_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// tb/tb_y86_fetch_unit.sv - directed self-checking bench for y86_fetch_unit
module tb_y86_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] F_predPC = '0;
  logic [3:0]  M_icode = '0;
  logic        M_Cnd = 1'b0;
  logic [63:0] M_valA = '0;
  logic [3:0]  W_icode = '0;
  logic [63:0] W_valM = '0;
  logic        ret_pending = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic        imem_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP, f_PC_PREDICT;
  logic [1:0]  f_stat;
  logic        f_busy;

  logic [7:0]  mem [0:511];
  logic        err_en = 1'b0;
  logic [63:0] err_addr = '0;
  logic [63:0] req_log [$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc;

  y86_fetch_unit dut (
    .clk(clk), .reset(reset), .F_predPC(F_predPC), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM), .ret_pending(ret_pending),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err), .out_valid(out_valid),
    .out_ready(out_ready), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .f_PC_PREDICT(f_PC_PREDICT), .f_stat(f_stat),
    .f_busy(f_busy)
  );

  always #5 clk = ~clk;

  // Zero-wait memory: ack in the same cycle as the request.
  assign imem_ack   = imem_req;
  assign imem_rdata = mem[imem_addr[8:0]];
  assign imem_err   = err_en && (imem_addr == err_addr);

  always @(posedge clk) if (!reset && imem_req && imem_ack) req_log.push_back(imem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_out(output int c);
    c = 0;
    while (!out_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_req",   64'(imem_req), 64'd0);
    check("rst_addr",  imem_addr, 64'd0);
    check("rst_icode", 64'(f_icode), 64'd0);
    check("rst_rA",    64'(f_rA), 64'hF);
    check("rst_rB",    64'(f_rB), 64'hF);
    check("rst_valC",  f_valC, 64'd0);
    check("rst_valP",  f_valP, 64'd0);
    check("rst_pred",  f_PC_PREDICT, 64'd0);
    check("rst_stat",  64'(f_stat), 64'd1);
    req_log.delete();
    reset = 1'b0;
  endtask

  task automatic idle_halt(input string tag);
    req_log.delete();
    repeat (10) @(negedge clk);
    check({tag, "_reqs"}, 64'(req_log.size()), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[0]   = 8'h30; mem[1]   = 8'hF2; mem[2]  = 8'h0A;
    mem[32]  = 8'h80; mem[33]  = 8'h40;
    mem[21]  = 8'h10;
    mem[256] = 8'h61; mem[257] = 8'h23;
    mem[64]  = 8'h30; mem[65]  = 8'hF5; mem[66] = 8'h11; mem[67] = 8'h22;
    mem[96]  = 8'hF0;

    do_reset();

    // irmovq $0xA, %rdx at 0
    wait_out(cyc);
    check("irm_lat", 64'(cyc), 64'd11);
    check("irm_nreq", 64'(req_log.size()), 64'd10);
    for (int i = 0; i < 10 && i < req_log.size(); i++) check("irm_addr", req_log[i], 64'(i));
    check("irm_icode", 64'(f_icode), 64'd3);
    check("irm_rA", 64'(f_rA), 64'hF);
    check("irm_rB", 64'(f_rB), 64'd2);
    check("irm_valC", f_valC, 64'hA);
    check("irm_valP", f_valP, 64'hA);
    check("irm_pred", f_PC_PREDICT, 64'hA);
    check("irm_stat", 64'(f_stat), 64'd1);
    check("irm_busy", 64'(f_busy), 64'd0);
    repeat (5) @(negedge clk);
    check("hold_valid", 64'(out_valid), 64'd1);
    check("hold_valC", f_valC, 64'hA);
    check("hold_rB", 64'(f_rB), 64'd2);

    // call 0x40 at 0x20
    F_predPC = 64'h20;
    accept();
    req_log.delete();
    wait_out(cyc);
    check("call_lat", 64'(cyc), 64'd10);
    check("call_addr0", req_log.size() > 0 ? req_log[0] : 64'hDEAD, 64'h20);
    check("call_icode", 64'(f_icode), 64'd8);
    check("call_valC", f_valC, 64'h40);
    check("call_valP", f_valP, 64'h29);
    check("call_pred", f_PC_PREDICT, 64'h40);

    // mispredicted jXX beats a concurrent ret
    F_predPC = 64'h80; M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h15;
    W_icode = 4'h9; W_valM = 64'h100;
    accept();
    req_log.delete();
    wait_out(cyc);
    check("jxx_lat", 64'(cyc), 64'd2);
    check("jxx_addr0", req_log.size() > 0 ? req_log[0] : 64'hDEAD, 64'h15);
    check("jxx_icode", 64'(f_icode), 64'd1);
    check("jxx_valP", f_valP, 64'h16);

    // ret: stall while ret_pending, then fetch at W_valM
    M_icode = 4'h0; ret_pending = 1'b1;
    accept();
    req_log.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ret_stall_req", 64'(imem_req), 64'd0);
    end
    check("ret_stall_busy", 64'(f_busy), 64'd1);
    ret_pending = 1'b0;
    wait_out(cyc);
    check("ret_lat", 64'(cyc), 64'd3);
    check("ret_addr0", req_log.size() > 0 ? req_log[0] : 64'hDEAD, 64'h100);
    check("ret_icode", 64'(f_icode), 64'd6);
    check("ret_ifun", 64'(f_ifun), 64'd1);
    check("ret_rA", 64'(f_rA), 64'd2);
    check("ret_rB", 64'(f_rB), 64'd3);
    check("ret_valP", f_valP, 64'h102);
    check("ret_pred", f_PC_PREDICT, 64'h102);

    // imem_err on byte 3 of irmovq at 0x40
    W_icode = 4'h0; F_predPC = 64'h40; err_en = 1'b1; err_addr = 64'h43;
    accept();
    req_log.delete();
    wait_out(cyc);
    check("adr_lat", 64'(cyc), 64'd5);
    check("adr_nreq", 64'(req_log.size()), 64'd4);
    check("adr_stat", 64'(f_stat), 64'd3);
    check("adr_icode", 64'(f_icode), 64'd3);
    check("adr_rA", 64'(f_rA), 64'hF);
    check("adr_rB", 64'(f_rB), 64'd5);
    check("adr_valC", f_valC, 64'd0);
    accept();
    err_en = 1'b0;
    idle_halt("adr_halt");

    // reset in the middle of byte 5
    F_predPC = 64'h0;
    do_reset();
    cyc = 0;
    while (!(imem_req && imem_addr == 64'd5) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reached", 64'(imem_addr), 64'd5);
    reset = 1'b1;
    @(negedge clk);
    check("mid_req", 64'(imem_req), 64'd0);
    check("mid_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    req_log.delete();
    wait_out(cyc);
    check("mid_relat", 64'(cyc), 64'd11);
    check("mid_valC", f_valC, 64'hA);

    // invalid icode 0xF at 0x60
    F_predPC = 64'h60;
    accept();
    req_log.delete();
    wait_out(cyc);
    check("ins_lat", 64'(cyc), 64'd2);
    check("ins_nreq", 64'(req_log.size()), 64'd1);
    check("ins_stat", 64'(f_stat), 64'd0);
    check("ins_icode", 64'(f_icode), 64'hF);
    check("ins_rA", 64'(f_rA), 64'hF);
    accept();
    idle_halt("ins_halt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
